// File: rtl/tone_pkg.sv
// tone_pkg: note table, FSM states and cycle-count helpers for tone_gen
package tone_pkg;
  localparam int NUM_NOTES = 21;
  localparam int unsigned CENTI_HZ [NUM_NOTES] = '{
    13081, 14683, 16481, 17461, 19600, 22000, 24694,
    26163, 29366, 32963, 34923, 39200, 44000, 49388,
    52325, 58733, 65926, 69846, 78399, 88000, 98777
  };
  typedef enum logic {IDLE, PLAY} state_t;
  function automatic int unsigned half_period(input longint unsigned clk_hz, input int unsigned idx);
    longint unsigned c;
    if (idx < 1 || idx > NUM_NOTES) return 1;
    c = 64'(CENTI_HZ[idx - 1]);
    return 32'((clk_hz * 50 + c / 2) / c);
  endfunction
  function automatic int unsigned hold_cycles(input longint unsigned clk_hz, input int unsigned ms);
    return 32'(clk_hz / 1000 * 64'(ms));
  endfunction
endpackage

// File: rtl/note_divider.sv
// note_divider: loadable half-period counter driving a square-wave toggle flop
module note_divider #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] half,
  output logic         sq
);
  logic [W-1:0] r_half;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_half <= '0;
      r_cnt  <= '0;
      sq     <= 1'b0;
    end else if (load) begin
      r_half <= half;
      r_cnt  <= '0;
      sq     <= 1'b1;
    end else if (r_cnt == r_half - 1'b1) begin
      r_cnt <= '0;
      sq    <= ~sq;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tone_gen.sv
// tone_gen: timed square-wave note player with retrigger and mute
module tone_gen
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int HOLD_MS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_valid,
  input  logic [4:0] note_idx,
  input  logic       mute,
  output logic       audio_out,
  output logic       playing,
  output logic [4:0] cur_note
);
  localparam int unsigned D    = hold_cycles(64'(CLK_HZ), HOLD_MS);
  localparam int unsigned HMAX = half_period(64'(CLK_HZ), 1);
  localparam int HW = $clog2(HMAX + 1);
  localparam int DW = $clog2(D + 1);
  logic [HW-1:0] w_rom [32];
  state_t        r_state, w_next;
  logic [4:0]    r_note;
  logic [DW-1:0] r_dur;
  logic          w_valid, w_sq, w_play;
  // out-of-range indices map to 1 so the ROM is fully populated
  for (genvar i = 0; i < 32; i++) begin : g_rom
    assign w_rom[i] = HW'(half_period(64'(CLK_HZ), i));
  end
  assign w_valid = note_valid && note_idx != 5'd0 && note_idx <= 5'(NUM_NOTES);
  assign w_play  = r_state == PLAY;
  always_comb begin
    w_next = w_valid ? PLAY : (w_play && r_dur == DW'(1)) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_note  <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_next;
      if (w_valid) r_note <= note_idx;
      if (w_valid) r_dur <= DW'(D);
      else if (w_play) r_dur <= r_dur - 1'b1;
    end
  end
  note_divider #(.W(HW)) u_div (
    .clk  (clk),
    .reset(reset),
    .load (w_valid),
    .half (w_rom[note_idx]),
    .sq   (w_sq)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out <= 1'b0;
      playing   <= 1'b0;
      cur_note  <= '0;
    end else begin
      audio_out <= w_sq & ~mute & w_play;
      playing   <= w_play;
      cur_note  <= w_play ? r_note : 5'd0;
    end
  end
endmodule
